bus_source_arbiter: RTL and testbench

- Round-robin arbiter for the shared 32-bit internal bus, with up to 32 source requesters (registers, ALU result, memory data, port in, ...).
- Drives a registered one-hot grant plus its 5-bit binary code, which feeds the bus source-select mux directly.
- Inserts a one-cycle dead turnaround between owners so two drivers never overlap.
- Optionally preempts an owner that holds the bus too long while others wait.

---
 rtl/bus_source_arbiter.sv | 112 +++++++++++
 tb/tb_bus_source_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_source_arbiter.sv
// Round-robin arbiter for the shared internal bus: registered one-hot grant plus
// binary code, a dead turnaround cycle between owners, and optional preemption.
module bus_source_arbiter #(
    parameter int unsigned N        = 32,
    parameter int unsigned CODE_W   = 5,
    parameter int unsigned MAX_HOLD = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N-1:0]      req,
    output logic [N-1:0]      grant,
    output logic [CODE_W-1:0] grant_code,
    output logic              grant_valid,
    output logic              preempt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_OWN,
        S_TURN
    } state_t;

    state_t              r_state;
    logic [N-1:0]        r_grant;
    logic [CODE_W-1:0]   r_grant_code;
    logic                r_grant_valid;
    logic                r_preempt;
    logic [CODE_W-1:0]   r_last_owner;
    logic [31:0]         r_hold_cnt;

    logic [CODE_W-1:0]   w_idx;
    logic [CODE_W-1:0]   w_winner;
    logic                w_found;
    logic                w_owner_req;
    logic                w_others_req;
    logic                w_hold_limit;

    // Scan upward from the slot after the last owner; the index wraps by truncation
    // because N is a power of two.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            w_idx = r_last_owner + CODE_W'(i + 1);
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_comb begin
        w_owner_req  = req[r_grant_code];
        w_others_req = |(req & ~r_grant);
        w_hold_limit = (MAX_HOLD != 0) && (r_hold_cnt == 32'(MAX_HOLD - 1));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_grant       <= '0;
            r_grant_code  <= '0;
            r_grant_valid <= 1'b0;
            r_preempt     <= 1'b0;
            r_last_owner  <= CODE_W'(N - 1);
            r_hold_cnt    <= '0;
        end else begin
            r_preempt <= 1'b0;
            case (r_state)
                S_IDLE, S_TURN: begin
                    if (w_found) begin
                        r_grant       <= N'(1) << w_winner;
                        r_grant_code  <= w_winner;
                        r_grant_valid <= 1'b1;
                        r_last_owner  <= w_winner;
                        r_hold_cnt    <= '0;
                        r_state       <= S_OWN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_OWN: begin
                    // A voluntary release takes precedence over preemption.
                    if (!w_owner_req) begin
                        r_grant       <= '0;
                        r_grant_code  <= '0;
                        r_grant_valid <= 1'b0;
                        r_state       <= S_TURN;
                    end else if (w_hold_limit && w_others_req) begin
                        r_grant       <= '0;
                        r_grant_code  <= '0;
                        r_grant_valid <= 1'b0;
                        r_preempt     <= 1'b1;
                        r_state       <= S_TURN;
                    end else if (r_hold_cnt != '1) begin
                        r_hold_cnt <= r_hold_cnt + 32'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign grant       = r_grant;
    assign grant_code  = r_grant_code;
    assign grant_valid = r_grant_valid;
    assign preempt     = r_preempt;

endmodule

// File: tb/tb_bus_source_arbiter.sv
// Self-checking bench for bus_source_arbiter: one instance without preemption and
// one with MAX_HOLD=4, driven from a vector table plus hand-written sequences.
module tb_bus_source_arbiter;

    logic        clock;
    logic        reset;
    logic [31:0] req0;
    logic [31:0] req1;
    logic [31:0] grant0;
    logic [31:0] grant1;
    logic [4:0]  code0;
    logic [4:0]  code1;
    logic        valid0;
    logic        valid1;
    logic        pre0;
    logic        pre1;

    int checks   = 0;
    int failures = 0;

    bus_source_arbiter #(.N(32), .CODE_W(5), .MAX_HOLD(0)) dut0 (
        .clock       (clock),
        .reset       (reset),
        .req         (req0),
        .grant       (grant0),
        .grant_code  (code0),
        .grant_valid (valid0),
        .preempt     (pre0)
    );

    bus_source_arbiter #(.N(32), .CODE_W(5), .MAX_HOLD(4)) dut1 (
        .clock       (clock),
        .reset       (reset),
        .req         (req1),
        .grant       (grant1),
        .grant_code  (code1),
        .grant_valid (valid1),
        .preempt     (pre1)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        string       name;
        bit          rst;
        bit          sel;
        logic [31:0] req;
        logic [31:0] g;
        logic [4:0]  c;
        logic        v;
        logic        p;
    } vec_t;

    typedef struct {
        string       name;
        bit          sel;
        logic [31:0] g;
        logic [4:0]  c;
        logic        v;
        logic        p;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string name, input bit sel, input logic [31:0] g,
                                 input logic [4:0] c, input logic v, input logic p);
        logic [31:0] ag;
        logic [4:0]  ac;
        logic        av;
        logic        ap;
        ag = sel ? grant1 : grant0;
        ac = sel ? code1  : code0;
        av = sel ? valid1 : valid0;
        ap = sel ? pre1   : pre0;
        check({name, ".grant"}, ag, g);
        check({name, ".code"},  32'(ac), 32'(c));
        check({name, ".valid"}, 32'(av), 32'(v));
        check({name, ".preempt"}, 32'(ap), 32'(p));
        check({name, ".onehot"}, 32'($countones(ag) <= 1), 32'd1);
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic step(input string name, input bit sel, input logic [31:0] r,
                        input logic [31:0] g, input logic [4:0] c, input logic v, input logic p);
        exp_t e;
        if (sel) begin req1 = r; req0 = '0; end
        else     begin req0 = r; req1 = '0; end
        e.name = name; e.sel = sel; e.g = g; e.c = c; e.v = v; e.p = p;
        sb.push_back(e);
        @(posedge clock);
        #1;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s.scoreboard: got empty queue expected 1 entry", name);
        end else begin
            e = sb.pop_front();
            check_outputs(e.name, e.sel, e.g, e.c, e.v, e.p);
        end
        @(negedge clock);
    endtask

    // Called at a negedge; reset held across one edge, released at the next negedge.
    task automatic do_reset(input string name, input logic [31:0] r);
        req0  = r;
        req1  = r;
        reset = 1'b1;
        #1;
        check_outputs({name, ".async"}, 1'b0, '0, '0, 1'b0, 1'b0);
        check_outputs({name, ".async1"}, 1'b1, '0, '0, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        check_outputs({name, ".held"}, 1'b0, '0, '0, 1'b0, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        req0  = '0;
        req1  = '0;
    endtask

    function automatic void add(input string n, input bit rst, input bit sel, input logic [31:0] r,
                                input logic [31:0] g, input logic [4:0] c, input logic v, input logic p);
        vec_t x;
        x.name = n; x.rst = rst; x.sel = sel; x.req = r; x.g = g; x.c = c; x.v = v; x.p = p;
        vecs.push_back(x);
    endfunction

    initial begin
        reset = 1'b1;
        req0  = '0;
        req1  = '0;

        add("first_bit0",  0, 0, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  1, 0);
        add("rel_turn",    0, 0, 32'h0,         32'h0,         5'd0,  0, 0);
        add("rel_idle",    0, 0, 32'h0,         32'h0,         5'd0,  0, 0);
        add("single",      0, 0, 32'h0000_0020, 32'h0000_0020, 5'd5,  1, 0);
        add("single_turn", 0, 0, 32'h0,         32'h0,         5'd0,  0, 0);
        add("single_idle", 0, 0, 32'h0,         32'h0,         5'd0,  0, 0);
        add("cont_b0",     1, 0, 32'h0000_0081, 32'h0000_0001, 5'd0,  1, 0);
        add("cont_turn",   0, 0, 32'h0000_0080, 32'h0,         5'd0,  0, 0);
        add("cont_b7",     0, 0, 32'h0000_0080, 32'h0000_0080, 5'd7,  1, 0);
        add("cont_turn2",  0, 0, 32'h0000_0001, 32'h0,         5'd0,  0, 0);
        add("cont_b0b",    0, 0, 32'h0000_0001, 32'h0000_0001, 5'd0,  1, 0);
        add("wrap_rel",    0, 0, 32'h0,         32'h0,         5'd0,  0, 0);
        add("wrap_b31",    0, 0, 32'h8000_0000, 32'h8000_0000, 5'd31, 1, 0);
        add("wrap_turn",   0, 0, 32'h0000_0001, 32'h0,         5'd0,  0, 0);
        add("wrap_b0",     0, 0, 32'h8000_0001, 32'h0000_0001, 5'd0,  1, 0);
        add("wrap_hold",   0, 0, 32'h8000_0001, 32'h0000_0001, 5'd0,  1, 0);
        add("wrap_turn2",  0, 0, 32'h8000_0000, 32'h0,         5'd0,  0, 0);
        add("wrap_b31b",   0, 0, 32'h8000_0000, 32'h8000_0000, 5'd31, 1, 0);
        add("pre_b2_0",    1, 1, 32'h0000_000C, 32'h0000_0004, 5'd2,  1, 0);
        add("pre_b2_1",    0, 1, 32'h0000_000C, 32'h0000_0004, 5'd2,  1, 0);
        add("pre_b2_2",    0, 1, 32'h0000_000C, 32'h0000_0004, 5'd2,  1, 0);
        add("pre_b2_3",    0, 1, 32'h0000_000C, 32'h0000_0004, 5'd2,  1, 0);
        add("pre_drop",    0, 1, 32'h0000_000C, 32'h0,         5'd0,  0, 1);
        add("pre_b3_0",    0, 1, 32'h0000_000C, 32'h0000_0008, 5'd3,  1, 0);
        add("pre_b3_1",    0, 1, 32'h0000_000C, 32'h0000_0008, 5'd3,  1, 0);
        add("pre_b3_2",    0, 1, 32'h0000_000C, 32'h0000_0008, 5'd3,  1, 0);
        add("pre_b3_3",    0, 1, 32'h0000_000C, 32'h0000_0008, 5'd3,  1, 0);
        add("pre_drop2",   0, 1, 32'h0000_000C, 32'h0,         5'd0,  0, 1);
        add("pre_b2b_0",   0, 1, 32'h0000_000C, 32'h0000_0004, 5'd2,  1, 0);
        add("pre_b2b_1",   0, 1, 32'h0000_000C, 32'h0000_0004, 5'd2,  1, 0);
        add("pre_b2b_2",   0, 1, 32'h0000_000C, 32'h0000_0004, 5'd2,  1, 0);
        add("pre_b2b_3",   0, 1, 32'h0000_000C, 32'h0000_0004, 5'd2,  1, 0);
        add("rel_at_lim",  0, 1, 32'h0000_0008, 32'h0,         5'd0,  0, 0);
        add("after_rel",   0, 1, 32'h0000_0008, 32'h0000_0008, 5'd3,  1, 0);

        @(negedge clock);
        do_reset("reset_all1", 32'hFFFF_FFFF);

        foreach (vecs[k]) begin
            if (vecs[k].rst) do_reset({vecs[k].name, ".rst"}, 32'h0);
            step(vecs[k].name, vecs[k].sel, vecs[k].req, vecs[k].g, vecs[k].c, vecs[k].v, vecs[k].p);
        end

        do_reset("uncont.rst", 32'h0);
        for (int i = 0; i < 10; i++) begin
            step("uncont_pre", 1'b1, 32'h0000_0004, 32'h0000_0004, 5'd2, 1'b1, 1'b0);
        end

        do_reset("nopre.rst", 32'h0);
        for (int i = 0; i < 8; i++) begin
            step("nopre_hold", 1'b0, 32'h0000_000C, 32'h0000_0004, 5'd2, 1'b1, 1'b0);
        end

        do_reset("midown.rst", 32'h0);
        step("own_b9", 1'b0, 32'h0000_0200, 32'h0000_0200, 5'd9, 1'b1, 1'b0);
        #2;
        req0  = '0;
        reset = 1'b1;
        #1;
        check_outputs("midown_async", 1'b0, '0, '0, 1'b0, 1'b0);
        #1;
        reset = 1'b0;
        @(negedge clock);
        step("after_rst_b8", 1'b0, 32'h0000_0300, 32'h0000_0100, 5'd8, 1'b1, 1'b0);
        step("after_rst_hold", 1'b0, 32'h0000_0300, 32'h0000_0100, 5'd8, 1'b1, 1'b0);

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no completion expected finish before 100000");
        $fatal(1);
    end

endmodule
